// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: shared types and constants for the VGA receive-side monitor.
package vga_rx_pkg;

  localparam int                 COORD_W   = 10;
  localparam logic [COORD_W-1:0] COORD_MAX = '1;
  localparam logic [COORD_W-1:0] COORD_ONE = {{(COORD_W-1){1'b0}}, 1'b1};

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

endpackage

// File: rtl/crc16_byte.sv
// crc16_byte: combinational CRC-16-CCITT update for one byte, MSB first.
module crc16_byte
  import vga_rx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  // shift the byte in one bit at a time, high bit first
  always_comb begin
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data_in[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                    c = {c[14:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: samples the VGA pins, rebuilds x/y, measures per-frame
// geometry, tracks lock and reports a per-frame pixel checksum.
// Optional feature macro: VGA_RX_CRC_EN builds the CRC-16-CCITT frame
// checksum; without it frame_crc reads 16'h0000.
module vga_rx_monitor
  import vga_rx_pkg::*;
#(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               de,
  input  logic [1:0]         r,
  input  logic [1:0]         g,
  input  logic [1:0]         b,
  output logic               pix_valid,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [5:0]         pix,
  output logic               frame_done,
  output logic [COORD_W-1:0] active_w,
  output logic [COORD_W-1:0] active_h,
  output logic               frame_ok,
  output logic [15:0]        frame_crc,
  output logic               locked,
  output logic [7:0]         err_cnt
);

  localparam logic [COORD_W-1:0] V_EXP = V_ACTIVE[COORD_W-1:0];
  localparam logic [COORD_W:0]   H_EXP = H_ACTIVE[COORD_W:0];

  // stage 1 (pins captured, syncs active-high)
  logic       hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d;
  logic [5:0] rgb1_q, rgb1_d;
  // stage 2 (pixel outputs) and sync history
  logic               pix_valid_q, pix_valid_d, vs2_q, vs2_d, vs3_q, vs3_d;
  logic [5:0]         pix_q, pix_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  // per-frame accumulators and closed-frame outputs
  logic               line_err_q, line_err_d, sync_err_q, sync_err_d;
  logic [COORD_W-1:0] last_w_q, last_w_d;
  logic               frame_done_q, frame_done_d, frame_ok_q, frame_ok_d;
  logic [COORD_W-1:0] active_w_q, active_w_d, active_h_q, active_h_d;
  rx_state_e          state_q, state_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic               de_rise, de_fall, vs_start, close, frame_good;
  logic [COORD_W:0]   line_w;
  logic [COORD_W-1:0] lines_cur, last_w_cur;
  logic               line_err_cur, sync_err_cur;

  // hsync is captured with the other pins but carries nothing the checks need
  logic unused_hs;
  assign unused_hs = hs1_q;

  // capture pins and fold sync polarity so everything downstream is active-high
  always_comb begin
    hs1_d  = hsync ^ SYNC_ACTIVE_LOW;
    vs1_d  = vsync ^ SYNC_ACTIVE_LOW;
    de1_d  = de;
    rgb1_d = {r, g, b};
  end

  assign de_rise  = de1_q & ~pix_valid_q;
  assign de_fall  = ~de1_q & pix_valid_q;
  assign vs_start = vs2_q & ~vs3_q;

  // coordinates, frame accumulators and the snapshot taken when a frame closes
  always_comb begin
    pix_valid_d = de1_q;
    pix_d       = rgb1_q;
    vs2_d       = vs1_q;
    vs3_d       = vs2_q;

    x_d = x_q;
    if (de_rise)                       x_d = '0;
    else if (de1_q && x_q != COORD_MAX) x_d = x_q + COORD_ONE;

    // a line ending this cycle belongs to the frame that may close this cycle
    line_w       = {1'b0, x_q} + {1'b0, COORD_ONE};
    lines_cur    = y_q;
    last_w_cur   = last_w_q;
    line_err_cur = line_err_q;
    if (de_fall) begin
      last_w_cur   = line_w[COORD_W] ? COORD_MAX : line_w[COORD_W-1:0];
      line_err_cur = line_err_q | (line_w != H_EXP);
      if (y_q != COORD_MAX) lines_cur = y_q + COORD_ONE;
    end
    sync_err_cur = sync_err_q | (pix_valid_q & vs2_q);
    frame_good   = (lines_cur == V_EXP) && !line_err_cur && !sync_err_cur;

    // the first vsync after reset only opens a frame; nothing is reported
    close = vs_start && (state_q != SEEK);

    y_d        = vs_start ? '0 : lines_cur;
    line_err_d = vs_start ? 1'b0 : line_err_cur;
    sync_err_d = vs_start ? 1'b0 : sync_err_cur;
    last_w_d   = last_w_cur;

    frame_done_d = close;
    active_w_d   = close ? last_w_cur : active_w_q;
    active_h_d   = close ? lines_cur  : active_h_q;
    frame_ok_d   = close ? frame_good : frame_ok_q;
  end

  // lock tracking: one good frame locks, one bad frame while locked drops it
  always_comb begin
    state_d   = state_q;
    err_cnt_d = err_cnt_q;
    if (vs_start) begin
      case (state_q)
        SEEK:    state_d = SYNC;
        SYNC:    if (frame_good) state_d = LOCKED;
        LOCKED:  if (!frame_good) begin
                   state_d = SYNC;
                   if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                 end
        default: state_d = SEEK;
      endcase
    end
  end

  // all pipeline, accumulator and report registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1_q        <= 1'b0;
      vs1_q        <= 1'b0;
      de1_q        <= 1'b0;
      rgb1_q       <= '0;
      pix_valid_q  <= 1'b0;
      pix_q        <= '0;
      vs2_q        <= 1'b0;
      vs3_q        <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      line_err_q   <= 1'b0;
      sync_err_q   <= 1'b0;
      last_w_q     <= '0;
      frame_done_q <= 1'b0;
      active_w_q   <= '0;
      active_h_q   <= '0;
      frame_ok_q   <= 1'b0;
      state_q      <= SEEK;
      err_cnt_q    <= '0;
    end else begin
      hs1_q        <= hs1_d;
      vs1_q        <= vs1_d;
      de1_q        <= de1_d;
      rgb1_q       <= rgb1_d;
      pix_valid_q  <= pix_valid_d;
      pix_q        <= pix_d;
      vs2_q        <= vs2_d;
      vs3_q        <= vs3_d;
      x_q          <= x_d;
      y_q          <= y_d;
      line_err_q   <= line_err_d;
      sync_err_q   <= sync_err_d;
      last_w_q     <= last_w_d;
      frame_done_q <= frame_done_d;
      active_w_q   <= active_w_d;
      active_h_q   <= active_h_d;
      frame_ok_q   <= frame_ok_d;
      state_q      <= state_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc_q, crc_d, crc_nxt, crc_cur, frame_crc_q, frame_crc_d;

  crc16_byte u_crc (
    .crc_in  (crc_q),
    .data_in ({2'b00, pix_q}),
    .crc_out (crc_nxt)
  );

  // running CRC over presented pixels; snapshot at close, restart every vsync
  always_comb begin
    crc_cur     = pix_valid_q ? crc_nxt : crc_q;
    crc_d       = vs_start ? CRC_INIT : crc_cur;
    frame_crc_d = close ? crc_cur : frame_crc_q;
  end

  // CRC state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q       <= CRC_INIT;
      frame_crc_q <= CRC_INIT;
    end else begin
      crc_q       <= crc_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign frame_crc = frame_crc_q;
`else
  assign frame_crc = 16'h0000;
`endif

  assign pix_valid  = pix_valid_q;
  assign x          = x_q;
  assign y          = y_q;
  assign pix        = pix_q;
  assign frame_done = frame_done_q;
  assign active_w   = active_w_q;
  assign active_h   = active_h_q;
  assign frame_ok   = frame_ok_q;
  assign locked     = (state_q == LOCKED);
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor: randomized frames driven into an active-low and an
// active-high instance; a pin-level reference model queues expected pixels
// and frame reports, a negedge monitor pops and compares them.
module tb_vga_rx_monitor;

  localparam int H = 8;
  localparam int V = 4;
`ifdef VGA_RX_CRC_EN
  localparam logic [15:0] CRC_RST = 16'hFFFF;
`else
  localparam logic [15:0] CRC_RST = 16'h0000;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic hs_b = 1'b0, vs_b = 1'b0, de = 1'b0;
  logic [1:0] r = '0, g = '0, b = '0;

  logic [1:0]       pv, fd, ok, lk;
  logic [1:0][9:0]  xo, yo, aw, ah;
  logic [1:0][5:0]  po;
  logic [1:0][15:0] crc;
  logic [1:0][7:0]  ec;

  int cyc = 0, total = 0, bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_rx_monitor #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .hsync(~hs_b), .vsync(~vs_b), .de(de),
    .r(r), .g(g), .b(b), .pix_valid(pv[0]), .x(xo[0]), .y(yo[0]), .pix(po[0]),
    .frame_done(fd[0]), .active_w(aw[0]), .active_h(ah[0]), .frame_ok(ok[0]),
    .frame_crc(crc[0]), .locked(lk[0]), .err_cnt(ec[0]));

  vga_rx_monitor #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .hsync(hs_b), .vsync(vs_b), .de(de),
    .r(r), .g(g), .b(b), .pix_valid(pv[1]), .x(xo[1]), .y(yo[1]), .pix(po[1]),
    .frame_done(fd[1]), .active_w(aw[1]), .active_h(ah[1]), .frame_ok(ok[1]),
    .frame_crc(crc[1]), .locked(lk[1]), .err_cnt(ec[1]));

  typedef struct { int cyc; logic [9:0] x; logic [9:0] y; logic [5:0] p; } pix_t;
  typedef struct { int cyc; logic [9:0] w; logic [9:0] h; logic ok;
                   logic [15:0] crc; logic lk; logic [7:0] ec; } frm_t;

  pix_t pq0[$], pq1[$];
  frm_t fq0[$], fq1[$];

  // reference model state, all at pin level
  int         m_run, m_lines, m_last_w, m_state, m_err;  // m_state: 0 seek, 1 sync, 2 locked
  bit         m_lerr, m_serr, m_pv, m_pd;
  logic [7:0] m_bytes[$];

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input logic [7:0] q[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (q[i])
      for (int j = 7; j >= 0; j--)
        c = (c[15] ^ q[i][j]) ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  task automatic model_reset;
    m_run = 0; m_lines = 0; m_last_w = 0; m_state = 0; m_err = 0;
    m_lerr = 0; m_serr = 0; m_pv = 0; m_pd = 0;
    m_bytes.delete();
    pq0.delete(); pq1.delete(); fq0.delete(); fq1.delete();
  endtask

  // apply one cycle of pins and let the model see it
  task automatic step(input bit v, input bit h, input bit d, input logic [5:0] p);
    pix_t pe;
    frm_t fe;
    bit   good;
    hs_b = h; vs_b = v; de = d; {r, g, b} = p;
    if (v && !m_pv) begin
      if (m_state != 0) begin
        good = (m_lines == V) && !m_lerr && !m_serr;
        if (m_state == 1 && good) m_state = 2;
        else if (m_state == 2 && !good) begin
          m_state = 1;
          if (m_err < 255) m_err++;
        end
        fe.cyc = cyc; fe.w = 10'(m_last_w); fe.h = 10'(m_lines); fe.ok = good;
`ifdef VGA_RX_CRC_EN
        fe.crc = crc16(m_bytes);
`else
        fe.crc = 16'h0000;
`endif
        fe.lk = (m_state == 2); fe.ec = 8'(m_err);
        fq0.push_back(fe); fq1.push_back(fe);
      end else m_state = 1;
      m_lines = 0; m_lerr = 0; m_serr = 0;
      m_bytes.delete();
    end
    if (d) begin
      if (v) m_serr = 1;
      m_bytes.push_back({2'b00, p});
      pe.cyc = cyc; pe.x = 10'(m_run); pe.y = 10'(m_lines); pe.p = p;
      pq0.push_back(pe); pq1.push_back(pe);
      m_run++;
    end else if (m_pd) begin
      m_lines++;
      m_last_w = m_run;
      if (m_run != H) m_lerr = 1;
      m_run = 0;
    end
    m_pv = v; m_pd = d;
    @(posedge clk); #1;
  endtask

  task automatic check_reset;
    for (int k = 0; k < 2; k++) begin
      chk("reset_outputs", k, {pv[k], xo[k], yo[k], po[k], fd[k], aw[k], ah[k], ok[k], lk[k], ec[k]}, '0);
      chk("reset_crc", k, crc[k], CRC_RST);
    end
  endtask

  task automatic do_reset;
    hs_b = 0; vs_b = 0; de = 0; {r, g, b} = '0;
    rst_n = 1'b0;
    model_reset;
    @(posedge clk); #1;
    check_reset;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // one frame: vsync pulse (optionally with stray de), then nl lines
  task automatic send_frame(input int nl, input int short_idx, input bit de_in_vs, input bit solid);
    repeat (3) step(1, 0, 0, '0);
    if (de_in_vs) repeat (2) step(1, 0, 1, 6'($urandom));
    step(1, 0, 0, '0);
    repeat (3) step(0, 0, 0, '0);
    for (int l = 0; l < nl; l++) begin
      repeat (3) step(0, 0, 0, '0);
      repeat ((l == short_idx) ? H - 1 : H) step(0, 0, 1, solid ? 6'h3F : 6'($urandom));
      repeat (2) step(0, 1, 0, '0);
      step(0, 0, 0, '0);
    end
  endtask

  // monitor: pop and compare whenever a DUT presents a pixel or a frame report
  always @(negedge clk) begin : mon
    pix_t pe;
    frm_t fe;
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (pv[k]) begin
          if ((k == 0 ? pq0.size() : pq1.size()) == 0) begin
            total++; bad++;
            $display("FAIL pix_unexpected dut%0d: got x=%0d y=%0d expected no pixel", k, xo[k], yo[k]);
          end else begin
            if (k == 0) pe = pq0.pop_front(); else pe = pq1.pop_front();
            chk("pix_latency", k, cyc - pe.cyc, 2);
            chk("pix_x_y_rgb", k, {xo[k], yo[k], po[k]}, {pe.x, pe.y, pe.p});
          end
        end
        if (fd[k]) begin
          if ((k == 0 ? fq0.size() : fq1.size()) == 0) begin
            total++; bad++;
            $display("FAIL frame_done_unexpected dut%0d: got pulse expected none", k);
          end else begin
            if (k == 0) fe = fq0.pop_front(); else fe = fq1.pop_front();
            chk("frame_latency", k, cyc - fe.cyc, 3);
            chk("active_w", k, aw[k], fe.w);
            chk("active_h", k, ah[k], fe.h);
            chk("frame_ok", k, ok[k], fe.ok);
            chk("frame_crc", k, crc[k], fe.crc);
            chk("locked", k, lk[k], fe.lk);
            chk("err_cnt", k, ec[k], fe.ec);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset;
    // clean frames; the first vsync only opens
    repeat (4) send_frame(V, -1, 0, 0);
    // solid 0x3F frame for the checksum
    send_frame(V, -1, 0, 1);
    // short second line while locked
    send_frame(V, 1, 0, 0);
    repeat (2) send_frame(V, -1, 0, 0);
    // stray de inside vsync, then recovery
    send_frame(V, -1, 1, 0);
    repeat (2) send_frame(V, -1, 0, 0);
    // randomized geometry and faults
    repeat (8)
      send_frame($urandom_range(5, 3), ($urandom_range(3, 0) == 0) ? $urandom_range(V - 1, 0) : -1,
                 $urandom_range(4, 0) == 0, 0);
    // reset in the middle of a line
    repeat (3) step(0, 0, 0, '0);
    repeat (4) step(0, 0, 1, 6'($urandom));
    do_reset;
    repeat (3) send_frame(V, -1, 0, 0);
    send_frame(0, -1, 0, 0);
    repeat (10) step(0, 0, 0, '0);
    chk("pix_queue_drained", 0, pq0.size(), 0);
    chk("pix_queue_drained", 1, pq1.size(), 0);
    chk("frame_queue_drained", 0, fq0.size(), 0);
    chk("frame_queue_drained", 1, fq1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
